// File: rtl/clk_mode_sequencer_if.sv
// clk_mode_sequencer_if: mode-change handshake plus generator control outputs.
interface clk_mode_sequencer_if;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;
    logic       done;
    logic       err;
    logic [1:0] en_out;
    logic       div_rst;
    logic       gate_en;
    logic       busy;
    logic [1:0] cur_mode;
    modport master (
        output req_valid, req_mode,
        input  req_ready, done, err, en_out, div_rst, gate_en, busy, cur_mode
    );
    modport slave (
        input  req_valid, req_mode,
        output req_ready, done, err, en_out, div_rst, gate_en, busy, cur_mode
    );
endinterface

// File: rtl/clk_mode_sequencer.sv
// clk_mode_sequencer: glitch-free divider mode switch (gate, quiesce, hold, switch, settle, ungate).
// Define CLK_SEQ_MUL2_EN to make mode 11 (mul2) a legal request.
module clk_mode_sequencer #(
    parameter int QUIET_CYC  = 4,
    parameter int SETTLE_CYC = 10,
    parameter int CNT_W      = 4
) (
    input logic           clk_in,
    input logic           rst,
    clk_mode_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_BOOT, S_IDLE, S_GATE, S_HOLD, S_RELEASE, S_DONE} state_t;
    state_t     state, ns;
    logic [CNT_W-1:0] cnt;
    logic       pend;
    logic [1:0] lat_mode;
    logic       accept, legal;
    logic       ready_d, done_d, err_d, div_rst_d, gate_d, busy_d;
    logic [1:0] en_d, cur_d;
    assign accept = state == S_IDLE && bus.req_ready && bus.req_valid;
`ifdef CLK_SEQ_MUL2_EN
    assign legal = 1'b1;
`else
    assign legal = lat_mode != 2'b11;
`endif
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state        <= S_BOOT;
            cnt          <= '0;
            pend         <= 1'b0;
            lat_mode     <= 2'b00;
            bus.req_ready <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.en_out   <= 2'b00;
            bus.div_rst  <= 1'b1;
            bus.gate_en  <= 1'b0;
            bus.busy     <= 1'b1;
            bus.cur_mode <= 2'b00;
        end else begin
            state        <= ns;
            cnt          <= (ns != state) ? '0 : cnt + CNT_W'(1);
            pend         <= accept;
            lat_mode     <= accept ? bus.req_mode : lat_mode;
            bus.req_ready <= ready_d;
            bus.done     <= done_d;
            bus.err      <= err_d;
            bus.en_out   <= en_d;
            bus.div_rst  <= div_rst_d;
            bus.gate_en  <= gate_d;
            bus.busy     <= busy_d;
            bus.cur_mode <= cur_d;
        end
    end
    // A latched request is judged one cycle after acceptance, while still in IDLE.
    always_comb begin
        ns = state;
        case (state)
            S_BOOT:    ns = (cnt == CNT_W'(SETTLE_CYC - 1)) ? S_IDLE : S_BOOT;
            S_IDLE:    ns = (pend && legal && lat_mode != bus.cur_mode) ? S_GATE : S_IDLE;
            S_GATE:    ns = (cnt == CNT_W'(QUIET_CYC - 1)) ? S_HOLD : S_GATE;
            S_HOLD:    ns = (cnt == CNT_W'(1)) ? S_RELEASE : S_HOLD;
            S_RELEASE: ns = (cnt == CNT_W'(SETTLE_CYC - 1)) ? S_DONE : S_RELEASE;
            S_DONE:    ns = S_IDLE;
            default:   ns = S_BOOT;
        endcase
    end
    // Outputs are registered from the upcoming state so they align with state entry.
    always_comb begin
        gate_d    = ns == S_IDLE || ns == S_DONE;
        div_rst_d = ns == S_HOLD;
        busy_d    = ns != S_IDLE;
        ready_d   = ns == S_IDLE && !accept;
        done_d    = ns == S_DONE || (state == S_IDLE && pend && legal && lat_mode == bus.cur_mode);
        err_d     = state == S_IDLE && pend && !legal;
        en_d      = (ns == S_HOLD) ? lat_mode : bus.en_out;
        cur_d     = (ns == S_DONE) ? lat_mode : bus.cur_mode;
    end
endmodule

// File: tb/tb_clk_mode_sequencer.sv
// tb_clk_mode_sequencer: directed and random mode requests against a cycle-offset model.
module tb_clk_mode_sequencer;
    localparam int Q  = 4;
    localparam int S  = 10;
    localparam int DK = 1 + Q + 2 + S;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [1:0] m_cur = 2'b00;
    always #5 clk = ~clk;
    clk_mode_sequencer_if bus();
    clk_mode_sequencer #(.QUIET_CYC(Q), .SETTLE_CYC(S), .CNT_W(4)) dut (
        .clk_in(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic bit is_legal(input logic [1:0] m);
`ifdef CLK_SEQ_MUL2_EN
        return 1'b1;
`else
        return m != 2'b11;
`endif
    endfunction
    task automatic check_rst_vals(input string tag);
        check({tag, "_div_rst"}, 4'(bus.div_rst), 4'd1);
        check({tag, "_gate"}, 4'(bus.gate_en), 4'd0);
        check({tag, "_done"}, 4'(bus.done), 4'd0);
        check({tag, "_err"}, 4'(bus.err), 4'd0);
        check({tag, "_busy"}, 4'(bus.busy), 4'd1);
        check({tag, "_ready"}, 4'(bus.req_ready), 4'd0);
        check({tag, "_en"}, 4'(bus.en_out), 4'd0);
        check({tag, "_cur"}, 4'(bus.cur_mode), 4'd0);
    endtask
    task automatic do_boot();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_mode = 2'b00;
        repeat (3) @(negedge clk);
        check_rst_vals("reset");
        rst = 1'b1;
        m_cur = 2'b00;
        for (int k = 1; k <= S; k++) begin
            @(negedge clk);
            check("boot_gate", 4'(bus.gate_en), 4'(k >= S));
            check("boot_ready", 4'(bus.req_ready), 4'(k >= S));
            check("boot_busy", 4'(bus.busy), 4'(k < S));
            check("boot_div_rst", 4'(bus.div_rst), 4'd0);
        end
        check("boot_en", 4'(bus.en_out), 4'd0);
        check("boot_cur", 4'(bus.cur_mode), 4'd0);
    endtask
    task automatic do_req(input logic [1:0] m, input bit noise, input int cut_at);
        int w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 4'(bus.req_ready), 4'd1);
        bus.req_valid = 1'b1;
        bus.req_mode = m;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_mode = 2'($urandom);
        check("ready_drop", 4'(bus.req_ready), 4'd0);
        if (!is_legal(m) || m == m_cur) begin
            @(negedge clk);
            check("short_err", 4'(bus.err), 4'(!is_legal(m)));
            check("short_done", 4'(bus.done), 4'(is_legal(m)));
            check("short_gate", 4'(bus.gate_en), 4'd1);
            check("short_div_rst", 4'(bus.div_rst), 4'd0);
            check("short_en", 4'(bus.en_out), 4'(m_cur));
            check("short_cur", 4'(bus.cur_mode), 4'(m_cur));
            check("short_busy", 4'(bus.busy), 4'd0);
            @(negedge clk);
            check("short_pulse_end", 4'({bus.done, bus.err}), 4'd0);
            check("short_ready", 4'(bus.req_ready), 4'd1);
        end else begin
            for (int k = 1; k <= DK + 1; k++) begin
                if (noise && k < DK) begin
                    bus.req_valid = 1'($urandom);
                    bus.req_mode = 2'($urandom);
                end else begin
                    bus.req_valid = 1'b0;
                end
                @(negedge clk);
                if (k == cut_at) begin
                    #2 rst = 1'b0;
                    #1 check_rst_vals("cut");
                    bus.req_valid = 1'b0;
                    return;
                end
                check("seq_gate", 4'(bus.gate_en), 4'(k >= DK));
                check("seq_div_rst", 4'(bus.div_rst), 4'(k == Q + 1 || k == Q + 2));
                check("seq_en", 4'(bus.en_out), 4'(k >= Q + 1 ? m : m_cur));
                check("seq_done", 4'(bus.done), 4'(k == DK));
                check("seq_cur", 4'(bus.cur_mode), 4'(k >= DK ? m : m_cur));
                check("seq_busy", 4'(bus.busy), 4'(k <= DK));
                check("seq_ready", 4'(bus.req_ready), 4'(k > DK));
                check("seq_err", 4'(bus.err), 4'd0);
            end
            m_cur = m;
        end
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_mode = 2'b00;
        do_boot();
        do_req(2'b00, 1'b0, 0);
        do_req(2'b01, 1'b0, 0);
        do_req(2'b11, 1'b0, 0);
        do_req(2'b10, 1'b1, 0);
        for (int i = 0; i < 12; i++)
            do_req(2'($urandom_range(0, 3)), 1'($urandom), 0);
        do_req((m_cur == 2'b00) ? 2'b10 : 2'b00, 1'b0, Q + 2 + 5);
        repeat (2) @(negedge clk);
        check("cut_no_done", 4'(bus.done), 4'd0);
        do_boot();
        do_req(2'b01, 1'b0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
